// File: rtl/aes_pkt_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_pkt_sequencer_if
// Bundles every signal between the packet sequencer, its requester, the
// character RAM and the AES core. Clock and reset are not part of the bundle.
//   start/base_addr         request from the front end
//   busy/done/err           status back to the front end
//   ram_addr/ram_re/ram_we  RAM port owned by the sequencer
//   ram_wdata/ram_rdata     RAM data (read data valid the cycle after ram_re)
//   aes_en/aes_din          AES launch pulse and plaintext block
//   aes_dout/aes_done       AES ciphertext and completion level
// master: the environment side (requester, RAM, AES core).
// slave : the sequencer itself.
// ---------------------------------------------------------------------------
interface aes_pkt_sequencer_if;
  logic         start;
  logic [6:0]   base_addr;
  logic         busy;
  logic         done;
  logic         err;
  logic [6:0]   ram_addr;
  logic         ram_re;
  logic [31:0]  ram_rdata;
  logic         ram_we;
  logic [31:0]  ram_wdata;
  logic         aes_en;
  logic [127:0] aes_din;
  logic [127:0] aes_dout;
  logic         aes_done;

  modport master (
    output start, base_addr, ram_rdata, aes_dout, aes_done,
    input  busy, done, err, ram_addr, ram_re, ram_we, ram_wdata, aes_en, aes_din
  );

  modport slave (
    input  start, base_addr, ram_rdata, aes_dout, aes_done,
    output busy, done, err, ram_addr, ram_re, ram_we, ram_wdata, aes_en, aes_din
  );
endinterface

// File: rtl/aes_pkt_sequencer.sv
// ---------------------------------------------------------------------------
// aes_pkt_sequencer
// Runs one AES-128 encryption per packet stored in the 128x32 character RAM:
// reads five 7-bit-packed plaintext words, assembles the 128-bit block,
// launches the AES core, waits (with timeout) for completion and writes the
// ciphertext back as five marker-framed words plus an all-ones terminator.
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  aes_pkt_sequencer_if.slave (request/status, RAM port, AES port)
// Parameter:
//   TIMEOUT  WAIT cycles allowed for aes_done before aborting (1..255)
// All outputs are registered; their next values are decoded from the next
// state so they line up with the state they belong to.
// ---------------------------------------------------------------------------
module aes_pkt_sequencer #(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input logic                 clk,
  input logic                 rst,
  aes_pkt_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_FLUSH  = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Four 7-bit characters of a RAM word, MSB character first.
  function automatic logic [27:0] pack_fields(input logic [31:0] w);
    return {w[30:24], w[22:16], w[14:8], w[6:0]};
  endfunction

  // The fifth word only contributes 16 bits to the block.
  function automatic logic [15:0] pack_tail(input logic [31:0] w);
    return {w[17:16], w[14:8], w[6:0]};
  endfunction

  // Re-insert a marker bit above each 7-bit character.
  function automatic logic [31:0] frame_fields(input logic [27:0] f);
    return {1'b1, f[27:21], 1'b1, f[20:14], 1'b1, f[13:7], 1'b1, f[6:0]};
  endfunction

  // Output word j of the ciphertext write-back sequence.
  function automatic logic [31:0] out_word(input logic [127:0] c, input logic [2:0] j);
    logic [31:0] w;
    case (j)
      3'd0:    w = frame_fields(c[27:0]);
      3'd1:    w = frame_fields(c[55:28]);
      3'd2:    w = frame_fields(c[83:56]);
      3'd3:    w = frame_fields(c[111:84]);
      3'd4:    w = {1'b1, 7'b0, 1'b1, 5'b0, c[127:126], 1'b1, c[125:119], 1'b1, c[118:112]};
      3'd5:    w = 32'hFFFF_FFFF;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  state_t         state_r, state_s;
  logic [2:0]     idx_r, idx_s;
  logic [7:0]     wait_cnt_r, wait_cnt_s;
  logic [6:0]     base_r, base_s;
  logic [127:0]   pt_r, pt_s;
  logic [127:0]   ct_r, ct_s;
  logic           rd_pend_r;
  logic [2:0]     rd_idx_r;

  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           err_r, err_s;
  logic [6:0]     ram_addr_r, ram_addr_s;
  logic           ram_re_r, ram_re_s;
  logic           ram_we_r, ram_we_s;
  logic [31:0]    ram_wdata_r, ram_wdata_s;
  logic           aes_en_r, aes_en_s;
  logic [127:0]   aes_din_r, aes_din_s;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    wait_cnt_s = wait_cnt_r;
    base_s     = base_r;
    err_s      = err_r;
    ct_s       = ct_r;
    pt_s       = pt_r;

    // Read data arrives one cycle after its strobe; the last word lands in FLUSH.
    if (rd_pend_r) begin
      case (rd_idx_r)
        3'd0:    pt_s[27:0]    = pack_fields(bus.ram_rdata);
        3'd1:    pt_s[55:28]   = pack_fields(bus.ram_rdata);
        3'd2:    pt_s[83:56]   = pack_fields(bus.ram_rdata);
        3'd3:    pt_s[111:84]  = pack_fields(bus.ram_rdata);
        3'd4:    pt_s[127:112] = pack_tail(bus.ram_rdata);
        default: pt_s          = pt_r;
      endcase
    end else begin
      pt_s = pt_r;
    end

    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s = S_READ;
          idx_s   = 3'd0;
          base_s  = bus.base_addr;
          err_s   = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ: begin
        if (idx_r == 3'd4) begin
          state_s = S_FLUSH;
          idx_s   = 3'd0;
        end else begin
          idx_s   = idx_r + 3'd1;
        end
      end
      S_FLUSH: begin
        state_s = S_LAUNCH;
      end
      S_LAUNCH: begin
        // aes_done seen here belongs to a previous job and is ignored.
        state_s    = S_WAIT;
        wait_cnt_s = 8'd0;
      end
      S_WAIT: begin
        if (bus.aes_done) begin
          state_s = S_WRITE;
          idx_s   = 3'd0;
          ct_s    = bus.aes_dout;
        end else if (wait_cnt_r == 8'(TIMEOUT - 32'd1)) begin
          state_s = S_DONE;
          err_s   = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      S_WRITE: begin
        if (idx_r == 3'd5) begin
          state_s = S_DONE;
          idx_s   = 3'd0;
        end else begin
          idx_s   = idx_r + 3'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    busy_s   = (state_s != S_IDLE);
    done_s   = (state_s == S_DONE);
    ram_re_s = (state_s == S_READ);
    ram_we_s = (state_s == S_WRITE);
    aes_en_s = (state_s == S_LAUNCH);

    case (state_s)
      S_READ:  ram_addr_s = base_s + {4'b0, idx_s};
      S_WRITE: ram_addr_s = base_s + 7'd5 + {4'b0, idx_s};
      default: ram_addr_s = 7'd0;
    endcase

    if (state_s == S_WRITE) begin
      ram_wdata_s = out_word(ct_s, idx_s);
    end else begin
      ram_wdata_s = 32'h0000_0000;
    end

    // The block is presented at launch and then held until the next launch.
    if (state_s == S_LAUNCH) begin
      aes_din_s = pt_s;
    end else begin
      aes_din_s = aes_din_r;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= 3'd0;
      wait_cnt_r  <= 8'd0;
      base_r      <= 7'd0;
      pt_r        <= 128'd0;
      ct_r        <= 128'd0;
      rd_pend_r   <= 1'b0;
      rd_idx_r    <= 3'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      ram_addr_r  <= 7'd0;
      ram_re_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_wdata_r <= 32'd0;
      aes_en_r    <= 1'b0;
      aes_din_r   <= 128'd0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      wait_cnt_r  <= wait_cnt_s;
      base_r      <= base_s;
      pt_r        <= pt_s;
      ct_r        <= ct_s;
      rd_pend_r   <= ram_re_r;
      rd_idx_r    <= idx_r;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
      ram_addr_r  <= ram_addr_s;
      ram_re_r    <= ram_re_s;
      ram_we_r    <= ram_we_s;
      ram_wdata_r <= ram_wdata_s;
      aes_en_r    <= aes_en_s;
      aes_din_r   <= aes_din_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_re    = ram_re_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.aes_en    = aes_en_r;
  assign bus.aes_din   = aes_din_r;

endmodule

// File: tb/tb_aes_pkt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_pkt_sequencer
// Directed bench for aes_pkt_sequencer (TIMEOUT=4). Provides a behavioural
// 128x32 RAM and a small AES stand-in with selectable behaviour:
//   mode 0: aes_done rises L cycles after launch, aes_dout = launched block
//   mode 1: aes_done never rises
//   mode 2: aes_done stuck high, aes_dout = launched block
//   mode 3: aes_done after L cycles, aes_dout = fixed constant
// ---------------------------------------------------------------------------
module tb_aes_pkt_sequencer;

  localparam logic [31:0]  SENT   = 32'hDEAD_BEEF;
  localparam logic [127:0] C_FIX  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_pkt_sequencer_if bus ();

  aes_pkt_sequencer #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // RAM model
  logic [31:0] mem [128];
  logic        pl_we = 1'b0;
  logic [6:0]  pl_addr = 7'd0;
  logic [31:0] pl_data = 32'd0;
  int          wr_total = 0;
  int          both_cnt = 0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      wr_total <= wr_total + 1;
    end
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
    if (bus.ram_re && bus.ram_we) both_cnt <= both_cnt + 1;
  end

  // AES stand-in
  logic [1:0]   aes_mode = 2'd0;
  logic [7:0]   aes_l    = 8'd1;
  logic [7:0]   aes_cnt  = 8'd0;
  logic [127:0] aes_lat  = 128'd0;

  always @(posedge clk) begin
    if (bus.aes_en) begin
      aes_cnt <= aes_l;
      aes_lat <= bus.aes_din;
    end else if (aes_cnt != 8'd0) begin
      aes_cnt <= aes_cnt - 8'd1;
    end
  end

  assign bus.aes_done = (aes_mode == 2'd2) ? 1'b1 :
                        (aes_mode == 2'd1) ? 1'b0 : (aes_cnt == 8'd1);
  assign bus.aes_dout = (aes_mode == 2'd3) ? C_FIX : aes_lat;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ram_put(input logic [6:0] a, input logic [31:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  // Per-packet observation log, cycle numbers relative to the start cycle.
  int         l_en_cyc, l_en_cnt, l_we_cyc, l_we_cnt, l_done_cyc, l_rd_cnt;
  logic       l_rd_ok, l_err_start, l_err_done, l_busy_done;
  logic [6:0] l_we_addr;

  task automatic run_pkt(input logic [6:0] base, input bit hold);
    logic [6:0] ea;
    l_en_cyc = -1; l_en_cnt = 0; l_we_cyc = -1; l_we_cnt = 0; l_done_cyc = -1;
    l_rd_cnt = 0; l_rd_ok = 1'b1; l_err_start = 1'b1; l_err_done = 1'b0;
    l_busy_done = 1'b0; l_we_addr = 7'd0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    for (int rel = 1; rel <= 300; rel++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (rel == 1) l_err_start = bus.err;
      if (bus.ram_re) begin
        ea = base + 7'(l_rd_cnt);
        if (bus.ram_addr != ea) l_rd_ok = 1'b0;
        l_rd_cnt++;
      end
      if (bus.ram_we) begin
        if (l_we_cyc < 0) begin
          l_we_cyc  = rel;
          l_we_addr = bus.ram_addr;
        end
        l_we_cnt++;
      end
      if (bus.aes_en) begin
        if (l_en_cyc < 0) l_en_cyc = rel;
        l_en_cnt++;
      end
      if (bus.done) begin
        l_done_cyc  = rel;
        l_err_done  = bus.err;
        l_busy_done = bus.busy;
        break;
      end
    end
  endtask

  typedef struct {
    logic [6:0]  base;
    logic [31:0] w0;
    logic [31:0] w4;
    logic [1:0]  mode;
    logic [7:0]  lat;
    int          exp_en;
    int          exp_we;
    int          exp_done;
    logic        exp_err;
    int          exp_wcnt;
    logic [31:0] exp_j0;
    logic [31:0] exp_j4;
    logic [31:0] exp_j5;
  } vec_t;

  vec_t       vecs [5];
  logic [6:0] vb;
  logic [6:0] va;
  int         wr_before;
  bit         seen;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{base:7'd6,   w0:32'h41424344, w4:32'h00034546, mode:2'd0, lat:8'd3,
                exp_en:7, exp_we:11, exp_done:17, exp_err:1'b0, exp_wcnt:6,
                exp_j0:32'hC1C2C3C4, exp_j4:32'h8083C5C6, exp_j5:32'hFFFFFFFF};
    vecs[1] = '{base:7'd125, w0:32'h01020304, w4:32'h00010203, mode:2'd0, lat:8'd1,
                exp_en:7, exp_we:9, exp_done:15, exp_err:1'b0, exp_wcnt:6,
                exp_j0:32'h81828384, exp_j4:32'h80818283, exp_j5:32'hFFFFFFFF};
    vecs[2] = '{base:7'd20,  w0:32'h11111111, w4:32'h00000000, mode:2'd1, lat:8'd0,
                exp_en:7, exp_we:-1, exp_done:12, exp_err:1'b1, exp_wcnt:0,
                exp_j0:SENT, exp_j4:SENT, exp_j5:SENT};
    vecs[3] = '{base:7'd60,  w0:32'h10203040, w4:32'hFFFFFFFF, mode:2'd2, lat:8'd1,
                exp_en:7, exp_we:9, exp_done:15, exp_err:1'b0, exp_wcnt:6,
                exp_j0:32'h90A0B0C0, exp_j4:32'h8083FFFF, exp_j5:32'hFFFFFFFF};
    vecs[4] = '{base:7'd90,  w0:32'h00000000, w4:32'h00000000, mode:2'd3, lat:8'd2,
                exp_en:7, exp_we:10, exp_done:16, exp_err:1'b0, exp_wcnt:6,
                exp_j0:32'hB2D0E490, exp_j4:32'h808082A3, exp_j5:32'hFFFFFFFF};

    bus.start     = 1'b0;
    bus.base_addr = 7'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ctl", {bus.busy, bus.done, bus.err, bus.ram_re, bus.ram_we, bus.aes_en, bus.ram_addr}, 128'd0);
    chk("rst_wdata", bus.ram_wdata, 128'd0);
    chk("rst_din", bus.aes_din, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of WAIT
    aes_mode = 2'd1;
    bus.start     = 1'b1;
    bus.base_addr = 7'd50;
    for (int rel = 1; rel <= 9; rel++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("midrst_busy_before", bus.busy, 128'd1);
    wr_before = wr_total;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", {bus.busy, bus.done, bus.err, bus.ram_re, bus.ram_we, bus.aes_en, bus.ram_addr}, 128'd0);
    chk("midrst_wdata", bus.ram_wdata, 128'd0);
    chk("midrst_din", bus.aes_din, 128'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_write", wr_total, wr_before);
    chk("midrst_idle", bus.busy, 128'd0);

    // Table-driven packets
    for (int v = 0; v < 5; v++) begin
      vb = vecs[v].base;
      for (int i = 0; i < 4; i++) ram_put(vb + 7'(i), vecs[v].w0);
      ram_put(vb + 7'd4, vecs[v].w4);
      for (int j = 0; j < 6; j++) ram_put(vb + 7'd5 + 7'(j), SENT);
      aes_mode = vecs[v].mode;
      aes_l    = vecs[v].lat;
      run_pkt(vb, 1'b0);
      chk($sformatf("v%0d_err_cleared", v), l_err_start, 128'd0);
      chk($sformatf("v%0d_reads", v), {l_rd_ok, 32'(l_rd_cnt)}, {1'b1, 32'd5});
      chk($sformatf("v%0d_aes_en_cyc", v), l_en_cyc, vecs[v].exp_en);
      chk($sformatf("v%0d_aes_en_cnt", v), l_en_cnt, 128'd1);
      chk($sformatf("v%0d_first_we_cyc", v), l_we_cyc, vecs[v].exp_we);
      chk($sformatf("v%0d_we_cnt", v), l_we_cnt, vecs[v].exp_wcnt);
      va = (vecs[v].exp_wcnt != 0) ? vb + 7'd5 : 7'd0;
      chk($sformatf("v%0d_first_we_addr", v), l_we_addr, va);
      chk($sformatf("v%0d_done_cyc", v), l_done_cyc, vecs[v].exp_done);
      chk($sformatf("v%0d_err_at_done", v), l_err_done, vecs[v].exp_err);
      chk($sformatf("v%0d_busy_at_done", v), l_busy_done, 128'd1);
      @(negedge clk);
      chk($sformatf("v%0d_idle_status", v), {bus.busy, bus.done, bus.err}, {2'b00, vecs[v].exp_err});
      va = vb + 7'd5;
      chk($sformatf("v%0d_ram_j0", v), mem[va], vecs[v].exp_j0);
      va = vb + 7'd9;
      chk($sformatf("v%0d_ram_j4", v), mem[va], vecs[v].exp_j4);
      va = vb + 7'd10;
      chk($sformatf("v%0d_ram_j5", v), mem[va], vecs[v].exp_j5);
      va = vb + 7'd4;
      chk($sformatf("v%0d_src_intact", v), {mem[vb], mem[va]}, {vecs[v].w0, vecs[v].w4});
    end

    // start held high through a whole packet
    aes_mode = 2'd0;
    aes_l    = 8'd1;
    run_pkt(7'd70, 1'b1);
    chk("hold_done_cyc", l_done_cyc, 128'd15);
    chk("hold_single", {32'(l_en_cnt), 32'(l_rd_cnt), 32'(l_we_cnt)}, {32'd1, 32'd5, 32'd6});
    @(negedge clk);
    chk("hold_idle_gap", bus.busy, 128'd0);
    @(negedge clk);
    chk("hold_restart", {bus.busy, bus.ram_re, bus.ram_addr}, {1'b1, 1'b1, 7'd70});
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold_second_done", seen, 128'd1);

    chk("no_re_we_overlap", both_cnt, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
